// File: rtl/quat_pkg.sv
// Shared types for the quaternion magnitude scheduler: operand struct,
// Q2.30 magnitude type and the scheduler FSM state encoding.
package quat_pkg;

  localparam int QUAT_W = 64;

  typedef struct packed {
    logic signed [15:0] w;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } quat_t;

  typedef logic [31:0] mag_q2_30_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/quat_mag_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping modulo N), only while en is high.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/quat_mag_scheduler.sv
// Round-robin front end sharing one multi-cycle quaternion magnitude unit.
// Optional WAIT watchdog (mag_abort / resp_timeout ports) under MAG_TIMEOUT_EN.
module quat_mag_scheduler
  import quat_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [QUAT_W*NUM_REQ-1:0] req_quat,
  output logic                      mag_start,
  output quat_t                     mag_quat,
  input  logic                      mag_done,
  input  mag_q2_30_t                mag_result,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output mag_q2_30_t                resp_magnitude,
  output logic                      resp_zero,
  output logic                      busy,
`ifdef MAG_TIMEOUT_EN
  output logic                      mag_abort,
  output logic                      resp_timeout,
`endif
  output sched_state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready is only raised in IDLE
  // (requests) or implied by RESP (responses).

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("quat_mag_scheduler: unsupported parameter set");
  end

  sched_state_e          state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  arb_en;
  logic                  accept;
  logic                  done_hit;

  // Gated by rst_n so req_ready reads 0 while reset is held.
  assign arb_en = rst_n && (state == IDLE);

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign done_hit  = (state == WAIT) && mag_done;
  assign dbg_state = state;

`ifdef MAG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == WAIT) && !mag_done && (wait_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign mag_abort   = timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_timeout <= 1'b0;
    end else if (done_hit || (state == RESP && resp_ready)) begin
      resp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      resp_timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    mag_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        mag_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mag_done) state_nxt = RESP;
`ifdef MAG_TIMEOUT_EN
        else if (timeout_hit) state_nxt = RESP;
`endif
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      mag_quat <= '0;
      resp_id  <= '0;
    end else if (accept) begin
      mag_quat <= req_quat[grant_idx*QUAT_W +: QUAT_W];
      resp_id  <= grant_idx;
      rr_ptr   <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_magnitude <= '0;
      resp_zero      <= 1'b0;
    end else if (done_hit) begin
      resp_magnitude <= mag_result;
      resp_zero      <= (mag_result == '0);
    end
`ifdef MAG_TIMEOUT_EN
    else if (timeout_hit) begin
      resp_magnitude <= '0;
      resp_zero      <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_quat_mag_scheduler.sv
// Bench for quat_mag_scheduler: requester/magnitude-unit models, a response
// scoreboard and scenario tasks; timeout scenario built only with MAG_TIMEOUT_EN.
module tb_quat_mag_scheduler;
  import quat_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int TB_TIMEOUT = 8;
  localparam int W          = ID_W + 33;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [QUAT_W*NUM_REQ-1:0] req_quat;
  logic                      mag_start;
  logic [63:0]               mag_quat;
  logic                      mag_done;
  logic [31:0]               mag_result;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [31:0]               resp_magnitude;
  logic                      resp_zero;
  logic                      busy;
  sched_state_e              dbg_state;
`ifdef MAG_TIMEOUT_EN
  logic                      mag_abort;
  logic                      resp_timeout;
`endif

  quat_mag_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_quat(req_quat), .mag_start(mag_start), .mag_quat(mag_quat),
    .mag_done(mag_done), .mag_result(mag_result), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_magnitude(resp_magnitude),
    .resp_zero(resp_zero), .busy(busy),
`ifdef MAG_TIMEOUT_EN
    .mag_abort(mag_abort), .resp_timeout(resp_timeout),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // requester model: requester i stays valid until it has been accepted rq_target[i] times
  int          rq_target   [NUM_REQ];
  int          rq_accepted [NUM_REQ];
  logic [63:0] rq_quat     [NUM_REQ];

  always_comb begin
    req_valid = '0;
    req_quat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]           = rq_accepted[i] < rq_target[i];
      req_quat[64*i +: 64]   = rq_quat[i];
    end
  end

  always @(posedge clk) begin
    if (rst_n)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i]) rq_accepted[i] <= rq_accepted[i] + 1;
  end

  // magnitude unit model: deterministic pseudo-magnitude of the operand after mag_latency cycles
  function automatic logic [31:0] mag_fn(input logic [63:0] q);
    if (q == 64'h0) return 32'h0;
    return (q[63:32] ^ q[31:0]) | 32'h1;
  endfunction

  int          mag_latency = 3;
  logic        force_en    = 1'b0;
  logic [31:0] force_val   = 32'h0;
  logic        model_hold  = 1'b0;
  logic        stray_done  = 1'b0;
  logic        model_done;
  logic        model_busy;
  logic [31:0] model_result;
  int          model_cnt;
  logic [63:0] model_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done <= 1'b0; model_busy <= 1'b0; model_result <= '0; model_cnt <= 0; model_op <= '0;
    end else begin
      model_done <= 1'b0;
      if (mag_start) begin
        model_busy <= 1'b1; model_cnt <= mag_latency; model_op <= mag_quat;
      end else if (model_busy && !model_hold) begin
        if (model_cnt <= 1) begin
          model_done   <= 1'b1;
          model_result <= force_en ? force_val : mag_fn(model_op);
          model_busy   <= 1'b0;
        end else begin
          model_cnt <= model_cnt - 1;
        end
      end
    end
  end

  assign mag_done   = model_done | stray_done;
  assign mag_result = model_result;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  function automatic logic [W-1:0] mk_exp(input int id, input logic [31:0] mag, input logic zero);
    return {ID_W'(id), mag, zero};
  endfunction

  task automatic monitor_loop();
    logic [63:0]  op_at_start;
    logic [W-1:0] exp_v, act_v;
    op_at_start = '0;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk_cnt++;
        if ($countones(req_ready) != 1) $display("FAIL ready_onehot: got %b required one-hot", req_ready);
        else pass_cnt++;
      end
      if (mag_start) op_at_start = mag_quat;
      if (model_done) begin
        chk_cnt++;
        if (mag_quat !== op_at_start) $display("FAIL operand_stable: got %h required %h", mag_quat, op_at_start);
        else pass_cnt++;
      end
      if (resp_valid && resp_ready) begin
        chk_cnt++;
        act_v = {resp_id, resp_magnitude, resp_zero};
        if (exp_q.size() == 0) begin
          $display("FAIL resp_unexpected: got id=%0d mag=%h zero=%b with nothing expected", resp_id, resp_magnitude, resp_zero);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v)
            $display("FAIL resp: got id=%0d mag=%h zero=%b required id=%0d mag=%h zero=%b",
                     act_v[W-1 -: ID_W], act_v[32:1], act_v[0], exp_v[W-1 -: ID_W], exp_v[32:1], exp_v[0]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({req_ready, mag_start, resp_valid, resp_zero, busy} !== '0)
      $display("FAIL reset_ctrl: got %b required 0", {req_ready, mag_start, resp_valid, resp_zero, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({mag_quat, resp_id, resp_magnitude} !== '0)
      $display("FAIL reset_data: got %h required 0", {mag_quat, resp_id, resp_magnitude});
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
    else pass_cnt++;
`ifdef MAG_TIMEOUT_EN
    chk_cnt++;
    if ({mag_abort, resp_timeout} !== 2'b00) $display("FAIL reset_timeout_ports: got %b required 00", {mag_abort, resp_timeout});
    else pass_cnt++;
`endif
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    bit ok;
    for (int i = 0; i < NUM_REQ; i++) rq_quat[i] = {$urandom, $urandom} | 64'h1;
    mag_latency = $urandom_range(1, 6);
    for (int n = 0; n < 8; n++) exp_q.push_back(mk_exp(n % NUM_REQ, mag_fn(rq_quat[n % NUM_REQ]), 1'b0));
    for (int i = 0; i < NUM_REQ; i++) rq_target[i] += 2;
    wait_drain(400, ok);
    chk_cnt++;
    if (!ok) $display("FAIL round_robin_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit ok, seen;
    rq_quat[0]  = 64'h4000_0000_0000_0000;
    force_en    = 1'b1;
    force_val   = 32'h1000_0000;
    mag_latency = 5;
    exp_q.push_back(mk_exp(0, 32'h1000_0000, 1'b0));
    rq_target[0] += 1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin seen = 1'b1; break; end
    end
    chk_cnt++;
    if (!seen || mag_start !== 1'b0) $display("FAIL single_accept: got seen=%b start=%b required seen=1 start=0", seen, mag_start);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (mag_start !== 1'b1 || mag_quat !== 64'h4000_0000_0000_0000 || busy !== 1'b1)
      $display("FAIL single_start: got start=%b quat=%h busy=%b required 1 4000000000000000 1", mag_start, mag_quat, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (mag_start !== 1'b0) $display("FAIL single_start_pulse: got %b required 0", mag_start);
    else pass_cnt++;
    wait_drain(100, ok);
    chk_cnt++;
    if (!ok) $display("FAIL single_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
    force_en = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    rq_quat[0] = {$urandom, $urandom} | 64'h1;
    rq_quat[1] = {$urandom, $urandom} | 64'h1;
    rq_quat[3] = {$urandom, $urandom} | 64'h1;
    mag_latency = 2;
    exp_q.push_back(mk_exp(1, mag_fn(rq_quat[1]), 1'b0));
    exp_q.push_back(mk_exp(3, mag_fn(rq_quat[3]), 1'b0));
    exp_q.push_back(mk_exp(0, mag_fn(rq_quat[0]), 1'b0));
    rq_target[0] += 1; rq_target[1] += 1; rq_target[3] += 1;
    wait_drain(200, ok);
    chk_cnt++;
    if (!ok) $display("FAIL wrap_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_zero_hold();
    bit ok, seen;
    resp_ready  = 1'b0;
    rq_quat[2]  = 64'h0;
    mag_latency = 3;
    exp_q.push_back(mk_exp(2, 32'h0, 1'b1));
    rq_target[2] += 1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; break; end
    end
    chk_cnt++;
    if (!seen) $display("FAIL zero_resp_wait: got no resp_valid required resp_valid within 50 cycles");
    else pass_cnt++;
    @(posedge clk); #1;
    rq_quat[0] = {$urandom, $urandom} | 64'h1;
    exp_q.push_back(mk_exp(0, mag_fn(rq_quat[0]), 1'b0));
    rq_target[0] += 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_cnt++;
      if ({resp_valid, resp_id, resp_magnitude, resp_zero, req_ready} !== {1'b1, 2'd2, 32'h0, 1'b1, 4'h0})
        $display("FAIL zero_hold: got v=%b id=%0d mag=%h zero=%b ready=%b required v=1 id=2 mag=0 zero=1 ready=0",
                 resp_valid, resp_id, resp_magnitude, resp_zero, req_ready);
      else pass_cnt++;
`ifdef MAG_TIMEOUT_EN
      chk_cnt++;
      if (resp_timeout !== 1'b0) $display("FAIL zero_no_timeout: got %b required 0", resp_timeout);
      else pass_cnt++;
`endif
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_drain(100, ok);
    chk_cnt++;
    if (!ok) $display("FAIL zero_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_stray_done();
    bit ok, seen;
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({busy, resp_valid} !== 2'b00) $display("FAIL stray_idle: got busy=%b valid=%b required 0 0", busy, resp_valid);
    else pass_cnt++;
    rq_quat[3]  = {$urandom, $urandom} | 64'h1;
    mag_latency = 4;
    exp_q.push_back(mk_exp(3, mag_fn(rq_quat[3]), 1'b0));
    rq_target[3] += 1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mag_start) begin seen = 1'b1; break; end
    end
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (!seen || {busy, resp_valid} !== 2'b10)
      $display("FAIL stray_issue: got seen=%b busy=%b valid=%b required 1 1 0", seen, busy, resp_valid);
    else pass_cnt++;
    wait_drain(100, ok);
    chk_cnt++;
    if (!ok) $display("FAIL stray_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    rq_quat[1]  = {$urandom, $urandom} | 64'h1;
    mag_latency = 30;
    rq_target[1] += 1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mag_start) begin seen = 1'b1; break; end
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (!seen || {busy, resp_valid, mag_start, req_ready, resp_zero} !== '0 || {mag_quat, resp_id, resp_magnitude} !== '0 || dbg_state !== IDLE)
      $display("FAIL reset_mid: got seen=%b busy=%b state=%0d quat=%h id=%0d required seen=1 busy=0 state=0 quat=0 id=0",
               seen, busy, dbg_state, mag_quat, resp_id);
    else pass_cnt++;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    rq_quat[0]  = {$urandom, $urandom} | 64'h1;
    rq_quat[2]  = {$urandom, $urandom} | 64'h1;
    mag_latency = 2;
    exp_q.push_back(mk_exp(0, mag_fn(rq_quat[0]), 1'b0));
    exp_q.push_back(mk_exp(2, mag_fn(rq_quat[2]), 1'b0));
    rq_target[0] += 1; rq_target[2] += 1;
    wait_drain(200, ok);
    chk_cnt++;
    if (!ok) $display("FAIL reset_mid_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask

`ifdef MAG_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen;
    int aborts;
    model_hold = 1'b1;
    resp_ready = 1'b0;
    rq_quat[1] = {$urandom, $urandom} | 64'h1;
    exp_q.push_back(mk_exp(1, 32'h0, 1'b1));
    rq_target[1] += 1;
    seen = 1'b0; aborts = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mag_abort) aborts++;
      if (resp_valid) begin seen = 1'b1; break; end
    end
    chk_cnt++;
    if (!seen || aborts != 1) $display("FAIL timeout_abort: got seen=%b aborts=%0d required 1 1", seen, aborts);
    else pass_cnt++;
    chk_cnt++;
    if ({resp_timeout, resp_zero, resp_magnitude} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL timeout_resp: got to=%b zero=%b mag=%h required 1 1 0", resp_timeout, resp_zero, resp_magnitude);
    else pass_cnt++;
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_drain(100, ok);
    chk_cnt++;
    if (!ok) $display("FAIL timeout_drain: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq_quat[i] = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_zero_hold();
    test_stray_done();
    test_reset_mid();
`ifdef MAG_TIMEOUT_EN
    test_timeout();
`endif
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
